// File: rtl/demux_reg.sv
// demux_reg: write-side register file for the 4:1 register-select mux.
// Single writes by select, or a 4-word ordered burst with a done pulse.
module demux_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   selw,
  input  logic [N-1:0] d,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         burst,
  output logic [N-1:0] R_0,
  output logic [N-1:0] R_1,
  output logic [N-1:0] R_2,
  output logic [N-1:0] R_3,
  output logic [3:0]   loaded,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   loaded_q, loaded_d;
  logic [N-1:0] reg_q [4];
  logic [N-1:0] reg_d [4];

  logic         wr_en;
  logic [1:0]   wsel;
  logic [3:0]   wsel_oh;

  always_comb begin
    wr_ready = 1'b0;
    unique case (state_q)
      S_IDLE:  wr_ready = ~burst;
      S_BURST: wr_ready = 1'b1;
      default: wr_ready = 1'b0;
    endcase
    if (reset) wr_ready = 1'b0;
  end

  assign done  = (state_q == S_DONE);
  assign wr_en = wr_valid && wr_ready;
  assign wsel  = (state_q == S_BURST) ? ptr_q : selw;

  always_comb begin
    wsel_oh = 4'b0000;
    unique case (1'b1)
      (wsel == 2'd0): wsel_oh = 4'b0001;
      (wsel == 2'd1): wsel_oh = 4'b0010;
      (wsel == 2'd2): wsel_oh = 4'b0100;
      (wsel == 2'd3): wsel_oh = 4'b1000;
      default:        wsel_oh = 4'b0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    for (int i = 0; i < 4; i++) begin
      reg_d[i] = reg_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (burst) begin
          state_d  = S_BURST;
          ptr_d    = 2'd0;
          loaded_d = 4'b0000;
        end
      end
      S_BURST: begin
        if (wr_en) begin
          ptr_d = ptr_q + 2'd1;
          if (ptr_q == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = 2'd0;
      end
    endcase
    // wr_en already excludes the burst-start cycle and DONE
    if (wr_en) begin
      loaded_d = loaded_d | wsel_oh;
      for (int i = 0; i < 4; i++) begin
        if (wsel_oh[i]) reg_d[i] = d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      loaded_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  assign R_0    = reg_q[0];
  assign R_1    = reg_q[1];
  assign R_2    = reg_q[2];
  assign R_3    = reg_q[3];
  assign loaded = loaded_q;

endmodule

// File: tb/tb_demux_reg.sv
// Randomised and directed bench for demux_reg against a
// behavioural model of the register file and burst sequencing.
module tb_demux_reg;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   selw;
  logic [N-1:0] d;
  logic         wr_valid;
  logic         wr_ready;
  logic         burst;
  logic [N-1:0] R_0, R_1, R_2, R_3;
  logic [3:0]   loaded;
  logic         done;

  demux_reg #(.N(N)) dut (
    .clk(clk), .reset(reset), .selw(selw), .d(d),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .burst(burst),
    .R_0(R_0), .R_1(R_1), .R_2(R_2), .R_3(R_3),
    .loaded(loaded), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  // model: phase 0 = single mode, 1 = loading burst, 2 = done cycle
  logic [N-1:0] m_r [4] = '{default: '0};
  logic [3:0]   m_loaded = 4'b0;
  int           m_phase  = 0;
  int           m_cnt    = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_r      <= '{default: '0};
      m_loaded <= 4'b0;
      m_phase  <= 0;
      m_cnt    <= 0;
    end else if (m_phase == 0) begin
      if (burst) begin
        m_phase  <= 1;
        m_cnt    <= 0;
        m_loaded <= 4'b0;
      end else if (wr_valid) begin
        m_r[selw] <= d;
        m_loaded  <= m_loaded | (4'b1 << selw);
      end
    end else if (m_phase == 1) begin
      if (wr_valid) begin
        m_r[m_cnt] <= d;
        m_loaded   <= m_loaded | (4'b1 << m_cnt);
        m_cnt      <= (m_cnt + 1) % 4;
        if (m_cnt == 3) m_phase <= 2;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = !reset && ((m_phase == 0) ? !burst : (m_phase == 1));
    chk("R_0", 32'(R_0), 32'(m_r[0]));
    chk("R_1", 32'(R_1), 32'(m_r[1]));
    chk("R_2", 32'(R_2), 32'(m_r[2]));
    chk("R_3", 32'(R_3), 32'(m_r[3]));
    chk("loaded", 32'(loaded), 32'(m_loaded));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    if (done) ndone++;
  end

  task automatic cyc(logic r, logic b, logic v,
                     logic [1:0] s, logic [N-1:0] dd);
    reset = r; burst = b; wr_valid = v; selw = s; d = dd;
    @(posedge clk);
    #2;
  endtask

  task automatic run_burst(int gap);
    cyc(0, 1, 0, 2'b11, '0);
    cyc(0, 0, 1, 2'b11, 16'h0001);
    cyc(0, 0, 1, 2'b11, 16'h0002);
    for (int i = 0; i < gap; i++) cyc(0, 0, 0, 2'b11, 16'hDEAD);
    cyc(0, 0, 1, 2'b11, 16'h0003);
    cyc(0, 0, 1, 2'b11, 16'h0004);
    chk("burst_done_state", 32'(done), 32'd1);
    chk("burst_done_rdy", 32'(wr_ready), 32'd0);
    cyc(0, 0, 0, 2'b00, '0);
    chk("burst_R", {R_0[7:0], R_1[7:0], R_2[7:0], R_3[7:0]}, 32'h01020304);
    chk("burst_loaded", 32'(loaded), 32'hF);
    chk("burst_idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    cyc(1, 0, 0, 2'b00, '0);
    cyc(1, 0, 1, 2'b01, 16'h5555);
    chk("rst_rdy", 32'(wr_ready), 32'd0);
    reset = 0; wr_valid = 0;
    #1;
    chk("rst_rdy_release", 32'(wr_ready), 32'd1);
    chk("rst_R", 32'({R_0, R_1} | {R_2, R_3}), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    cyc(0, 0, 1, 2'b10, 16'hA5A5);
    chk("single_R2", 32'(R_2), 32'hA5A5);
    chk("single_loaded1", 32'(loaded), 32'b0100);
    chk("single_R0_hold", 32'(R_0), 32'h0);
    cyc(0, 0, 1, 2'b00, 16'h1234);
    chk("single_R0", 32'(R_0), 32'h1234);
    chk("single_loaded2", 32'(loaded), 32'b0101);
    chk("single_R2_hold", 32'(R_2), 32'hA5A5);

    run_burst(0);
    chk("ndone_1", 32'(ndone), 32'd1);
    run_burst(3);
    chk("ndone_2", 32'(ndone), 32'd2);

    reset = 0; burst = 1; wr_valid = 1; selw = 2'b01; d = 16'hFFFF;
    #1;
    chk("simul_rdy", 32'(wr_ready), 32'd0);
    @(posedge clk); #2;
    chk("simul_R1", 32'(R_1), 32'h0002);
    chk("simul_loaded", 32'(loaded), 32'd0);
    cyc(0, 0, 1, 2'b01, 16'hBEEF);
    chk("simul_R0", 32'(R_0), 32'hBEEF);
    chk("simul_R1_after", 32'(R_1), 32'h0002);
    cyc(0, 0, 1, 2'b01, 16'h0022);
    cyc(0, 0, 1, 2'b01, 16'h0033);
    cyc(0, 0, 1, 2'b01, 16'h0044);
    cyc(0, 0, 0, 2'b00, '0);
    chk("ndone_3", 32'(ndone), 32'd3);

    cyc(0, 1, 0, 2'b00, '0);
    cyc(0, 0, 1, 2'b00, 16'h1111);
    cyc(0, 0, 1, 2'b00, 16'h2222);
    cyc(1, 0, 1, 2'b00, 16'h3333);
    chk("midrst_R", 32'({R_0, R_1} | {R_2, R_3}), 32'd0);
    chk("midrst_loaded", 32'(loaded), 32'd0);
    cyc(0, 0, 1, 2'b11, 16'h7777);
    chk("midrst_R3", 32'(R_3), 32'h7777);
    chk("midrst_loaded2", 32'(loaded), 32'b1000);
    cyc(0, 0, 0, 2'b00, '0);
    cyc(0, 0, 0, 2'b00, '0);
    chk("midrst_ndone", 32'(ndone), 32'd3);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          16'($urandom));
    end
    cyc(1, 0, 0, 2'b00, '0);
    cyc(0, 0, 0, 2'b00, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
